hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001: Parameter NUM_REGS, default 32, number of architectural registers tracked; register 0 is hardwired zero.
REQ-002: Parameter ADDR_W, default 5, register address width; NUM_REGS SHALL equal 2**ADDR_W.
REQ-003: Parameter LAT_W, default 4, latency field width; the all-ones latency code is LAT_WAIT, meaning "until completion".
REQ-004: Parameter CNT_W, default 16, stall performance counter width.
REQ-005: clock  in  1  single clock; all state updates on the rising edge.
REQ-006: reset  in  1  synchronous, active-high reset.
REQ-007: issue_valid  in  1  a multi-cycle write-back instruction leaves EX this cycle.
REQ-008: issue_dst  in  ADDR_W  destination register of the issuing instruction.
REQ-009: issue_lat  in  LAT_W  cycles until the result is available; 0 means untracked; LAT_WAIT means variable latency.
REQ-010: complete_valid  in  1  a variable-latency result (divider or data memory controller) is written this cycle.
REQ-011: complete_dst  in  ADDR_W  register completed by complete_valid.
REQ-012: flush  in  1  discard all pending entries (exception or pipeline flush).
REQ-013: ID_Rs, ID_Rt  in  ADDR_W each  source registers of the instruction in ID.
REQ-014: ID_NeedRs, ID_NeedRt  in  1 each  the ID instruction needs that source.
REQ-015: ID_Stall  out  1  the ID instruction must hold.
REQ-016: issue_conflict  out  1  issue_valid targets a register that is already pending; the issue is refused.
REQ-017: pending_count  out  ADDR_W+1  number of registers currently pending.
REQ-018: stall_cycles  out  CNT_W  saturating count of cycles with ID_Stall=1.

Function
REQ-019: Each register r SHALL have a busy bit and a LAT_W-bit countdown; register 0 SHALL never become busy.
REQ-020: An issue SHALL be accepted when issue_valid=1, issue_dst!=0, issue_lat!=0, and issue_conflict=0. On acceptance, busy[dst]=1 and cnt[dst]=issue_lat on the next edge.
REQ-021: issue_conflict SHALL be combinational: issue_valid & (issue_dst!=0) & busy[issue_dst]. A refused issue SHALL leave all state unchanged.
REQ-022: For a busy entry with cnt not equal to LAT_WAIT, cnt SHALL decrement by 1 each cycle. When cnt=1, the entry SHALL clear at that edge. A result issued with latency L therefore blocks exactly L cycles after the issue edge.
REQ-023: An entry with cnt=LAT_WAIT SHALL never decrement. It SHALL clear only on complete_valid with a matching complete_dst.
REQ-024: complete_valid for a register that is not busy, or not in LAT_WAIT, SHALL be ignored.
REQ-025: ID_Stall SHALL be combinational and equal (ID_NeedRs & ID_Rs!=0 & busy[ID_Rs]) | (ID_NeedRt & ID_Rt!=0 & busy[ID_Rt]), evaluated on current-cycle state. A completion or expiry in the same cycle SHALL NOT release the stall until the next cycle.
REQ-026: Simultaneous issue and completion on the same register cannot both apply, because issue_conflict refuses the issue. An entry clearing this cycle SHALL still refuse the issue.
REQ-027: flush SHALL clear every busy bit and countdown at the next edge. An issue in the same cycle as flush SHALL be discarded. flush SHALL NOT clear stall_cycles.
REQ-028: pending_count SHALL be a registered population count of busy bits, updated with them; maximum NUM_REGS-1.
REQ-029: stall_cycles SHALL increment on every edge where ID_Stall=1 and SHALL saturate at all-ones.

Reset
REQ-030: While reset=1 at an edge, all busy bits and countdowns, pending_count, and stall_cycles SHALL become 0; reset SHALL override issue, complete, and flush.
REQ-031: After reset, ID_Stall=0 and issue_conflict depends only on inputs. Reset asserted mid-countdown SHALL abandon all pending entries.

Verification
REQ-032: Issue dst=5, lat=3; ID_NeedRs=1, ID_Rs=5 -> ID_Stall=1 for exactly 3 cycles after the issue edge, then 0; stall_cycles=3.
REQ-033: Issue dst=8, lat=LAT_WAIT; wait 20 cycles -> still stalled; complete_valid dst=8 -> ID_Stall=0 the following cycle; pending_count back to 0.
REQ-034: Issue dst=0, lat=5, with ID_Rs=0 needed -> no busy entry, ID_Stall=0, pending_count=0.
REQ-035: Pending dst=7 (lat=4); re-issue dst=7 -> issue_conflict=1, countdown unaffected. Issue dst=9 in the same cycle that 7 expires -> accepted; pending_count stays 1.
REQ-036: Three pending entries, then flush together with issue dst=3 -> next cycle pending_count=0, no stall on any register, stall_cycles retained.
REQ-037: Preload stall_cycles near all-ones via a long LAT_WAIT stall -> counter holds at all-ones; then reset -> every output reads 0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: tracks destinations of multi-cycle write-backs and
// stalls ID while a needed source is still pending.
module hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int LAT_W    = 4,
    parameter int CNT_W    = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_dst,
    input  logic [LAT_W-1:0]  issue_lat,
    input  logic              complete_valid,
    input  logic [ADDR_W-1:0] complete_dst,
    input  logic              flush,
    input  logic [ADDR_W-1:0] ID_Rs,
    input  logic [ADDR_W-1:0] ID_Rt,
    input  logic              ID_NeedRs,
    input  logic              ID_NeedRt,
    output logic              ID_Stall,
    output logic              issue_conflict,
    output logic [ADDR_W:0]   pending_count,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam logic [LAT_W-1:0] LAT_WAIT = '1;

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic [LAT_W-1:0]    cnt      [NUM_REGS];
    logic [LAT_W-1:0]    cnt_next [NUM_REGS];
    logic                issue_accept;
    logic [ADDR_W:0]     pop_next;

    assign issue_conflict = issue_valid & (issue_dst != '0) & busy[issue_dst];
    assign issue_accept   = issue_valid & (issue_dst != '0) & (issue_lat != '0)
                          & ~busy[issue_dst];

    assign ID_Stall = (ID_NeedRs & (ID_Rs != '0) & busy[ID_Rs])
                    | (ID_NeedRt & (ID_Rt != '0) & busy[ID_Rt]);

    always_comb begin
        busy_next = busy;
        cnt_next  = cnt;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (busy[r]) begin
                if (cnt[r] == LAT_WAIT) begin
                    if (complete_valid && complete_dst == ADDR_W'(r)) begin
                        busy_next[r] = 1'b0;
                        cnt_next[r]  = '0;
                    end
                end else if (cnt[r] == LAT_W'(1)) begin
                    busy_next[r] = 1'b0;
                    cnt_next[r]  = '0;
                end else begin
                    cnt_next[r] = cnt[r] - LAT_W'(1);
                end
            end
            // Accepted issues only ever target idle entries, so no overlap with the above.
            if (issue_accept && issue_dst == ADDR_W'(r)) begin
                busy_next[r] = 1'b1;
                cnt_next[r]  = issue_lat;
            end
        end
        busy_next[0] = 1'b0;
        cnt_next[0]  = '0;
        if (flush) begin
            busy_next = '0;
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_next[r] = '0;
            end
        end
    end

    always_comb begin
        pop_next = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            pop_next = pop_next + {{ADDR_W{1'b0}}, busy_next[r]};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy          <= '0;
            pending_count <= '0;
            stall_cycles  <= '0;
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            busy          <= busy_next;
            pending_count <= pop_next;
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= cnt_next[r];
            end
            if (ID_Stall && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; narrow stall counter so saturation is reachable.
module tb_hazard_scoreboard;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int LAT_W    = 4;
    localparam int CNT_W    = 8;

    logic              clock = 1'b0;
    logic              reset;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_dst;
    logic [LAT_W-1:0]  issue_lat;
    logic              complete_valid;
    logic [ADDR_W-1:0] complete_dst;
    logic              flush;
    logic [ADDR_W-1:0] ID_Rs;
    logic [ADDR_W-1:0] ID_Rt;
    logic              ID_NeedRs;
    logic              ID_NeedRt;
    logic              ID_Stall;
    logic              issue_conflict;
    logic [ADDR_W:0]   pending_count;
    logic [CNT_W-1:0]  stall_cycles;

    int vectors     = 0;
    int miscompares = 0;

    hazard_scoreboard #(
        .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .LAT_W(LAT_W), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid), .issue_dst(issue_dst), .issue_lat(issue_lat),
        .complete_valid(complete_valid), .complete_dst(complete_dst),
        .flush(flush),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_NeedRs(ID_NeedRs), .ID_NeedRt(ID_NeedRt),
        .ID_Stall(ID_Stall), .issue_conflict(issue_conflict),
        .pending_count(pending_count), .stall_cycles(stall_cycles)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; issue_valid = 1'b0; issue_dst = '0; issue_lat = '0;
        complete_valid = 1'b0; complete_dst = '0; flush = 1'b0;
        ID_Rs = '0; ID_Rt = '0; ID_NeedRs = 1'b0; ID_NeedRt = 1'b0;
        step(); step();
        reset = 1'b0;
        #1;
        chk("rst_stall", 32'(ID_Stall), 0);
        chk("rst_pending", 32'(pending_count), 0);
        chk("rst_stallcnt", 32'(stall_cycles), 0);
        issue_valid = 1'b1; issue_dst = 5'd5; issue_lat = 4'd3;
        ID_NeedRs = 1'b1; ID_Rs = 5'd5;
        #1;
        chk("rst_conflict_idle", 32'(issue_conflict), 0);
        chk("lat3_pre_stall", 32'(ID_Stall), 0);

        // Fixed latency 3 on r5
        step();
        issue_valid = 1'b0;
        #1;
        chk("lat3_pending", 32'(pending_count), 1);
        for (int i = 0; i < 3; i++) begin
            chk("lat3_stall_on", 32'(ID_Stall), 1);
            step();
        end
        chk("lat3_stall_off", 32'(ID_Stall), 0);
        chk("lat3_stallcnt", 32'(stall_cycles), 3);
        chk("lat3_pending_0", 32'(pending_count), 0);

        // Variable latency on r8
        issue_valid = 1'b1; issue_dst = 5'd8; issue_lat = 4'hF; ID_Rs = 5'd8;
        step();
        issue_valid = 1'b0;
        repeat (20) step();
        chk("wait_stall_held", 32'(ID_Stall), 1);
        chk("wait_pending", 32'(pending_count), 1);
        chk("wait_stallcnt", 32'(stall_cycles), 23);
        complete_valid = 1'b1; complete_dst = 5'd8;
        #1;
        chk("wait_same_cycle_stall", 32'(ID_Stall), 1);
        step();
        complete_valid = 1'b0;
        #1;
        chk("wait_released", 32'(ID_Stall), 0);
        chk("wait_pending_0", 32'(pending_count), 0);
        chk("wait_stallcnt_2", 32'(stall_cycles), 24);

        // Register 0 never tracked
        issue_valid = 1'b1; issue_dst = 5'd0; issue_lat = 4'd5; ID_Rs = 5'd0;
        #1;
        chk("r0_conflict", 32'(issue_conflict), 0);
        step();
        issue_valid = 1'b0;
        #1;
        chk("r0_pending", 32'(pending_count), 0);
        chk("r0_stall", 32'(ID_Stall), 0);
        ID_NeedRs = 1'b0;

        // Conflict on r7, then issue r9 in r7's expiry cycle
        issue_valid = 1'b1; issue_dst = 5'd7; issue_lat = 4'd4;
        step();
        issue_lat = 4'd2;
        #1;
        chk("r7_conflict", 32'(issue_conflict), 1);
        step();
        issue_valid = 1'b0;
        #1;
        chk("r7_pending", 32'(pending_count), 1);
        step(); step();
        chk("r7_still_busy", 32'(pending_count), 1);
        issue_valid = 1'b1; issue_dst = 5'd9; issue_lat = 4'd2;
        ID_NeedRt = 1'b1; ID_Rt = 5'd7;
        #1;
        chk("r9_conflict", 32'(issue_conflict), 0);
        chk("r7_last_cycle_stall", 32'(ID_Stall), 1);
        step();
        issue_valid = 1'b0;
        #1;
        chk("r9_pending", 32'(pending_count), 1);
        chk("r7_expired", 32'(ID_Stall), 0);
        chk("r9_stallcnt", 32'(stall_cycles), 25);
        ID_NeedRt = 1'b0;
        step(); step();
        chk("r9_expired", 32'(pending_count), 0);

        // Completion on a fixed-latency entry is ignored
        issue_valid = 1'b1; issue_dst = 5'd10; issue_lat = 4'd3;
        step();
        issue_valid = 1'b0; complete_valid = 1'b1; complete_dst = 5'd10;
        step();
        complete_valid = 1'b0;
        #1;
        chk("cmp_ignored", 32'(pending_count), 1);
        step(); step();
        chk("cmp_expired", 32'(pending_count), 0);

        // Flush with three pending and a concurrent issue
        issue_valid = 1'b1; issue_dst = 5'd12; issue_lat = 4'hF;
        step();
        issue_dst = 5'd13;
        step();
        issue_dst = 5'd14; issue_lat = 4'd8;
        step();
        issue_valid = 1'b0;
        #1;
        chk("flush_pre_pending", 32'(pending_count), 3);
        flush = 1'b1; issue_valid = 1'b1; issue_dst = 5'd3; issue_lat = 4'd5;
        step();
        flush = 1'b0; issue_valid = 1'b0;
        ID_NeedRs = 1'b1; ID_Rs = 5'd12; ID_NeedRt = 1'b1; ID_Rt = 5'd3;
        #1;
        chk("flush_pending", 32'(pending_count), 0);
        chk("flush_stall", 32'(ID_Stall), 0);
        chk("flush_stallcnt_kept", 32'(stall_cycles), 25);
        ID_Rs = 5'd14; ID_Rt = 5'd13;
        #1;
        chk("flush_stall_2", 32'(ID_Stall), 0);
        ID_NeedRt = 1'b0;

        // Saturate stall counter, then reset everything
        issue_valid = 1'b1; issue_dst = 5'd20; issue_lat = 4'hF; ID_Rs = 5'd20;
        step();
        issue_valid = 1'b0;
        repeat (300) step();
        chk("sat_stallcnt", 32'(stall_cycles), 255);
        chk("sat_stall", 32'(ID_Stall), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        issue_valid = 1'b1; issue_dst = 5'd20; issue_lat = 4'd2;
        #1;
        chk("post_rst_stall", 32'(ID_Stall), 0);
        chk("post_rst_pending", 32'(pending_count), 0);
        chk("post_rst_stallcnt", 32'(stall_cycles), 0);
        chk("post_rst_conflict", 32'(issue_conflict), 0);
        issue_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
